commit_trace_checker: RTL and testbench
=======================================

# commit_trace_checker

Synthesizable consumer of the CPU's retire-event interface. It captures register writes, loads, stores and halt from the `cpu` pipeline (WB and MEM stages) and buffers them as trace records. It compares them in order against an expected-record stream delivered over a valid/ready handshake. It sits beside `cpu` in the phase-2 bench and FPGA harness, and gives a hardware pass/fail verdict equivalent to diffing the `.ptrace` file.

## Interface

Parameters:
- `FIFO_DEPTH`, default 8: observed-record buffer depth; power of 2, at least 4.
- `MAX_CYCLES`, default 100000: run-phase cycle limit before timeout.
- `DRAIN_TIMEOUT`, default 256: cycles allowed in DRAIN without an expected-stream handshake.

Ports (direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `RegWrite` in 1: register file written this cycle.
- `dstReg` in 4: destination register.
- `data_write_reg` in 16: register write data.
- `MEM_MemRead` in 1: load in the MEM stage.
- `MEM_MemWrite` in 1: store in the MEM stage.
- `MEM_ALU_result` in 16: memory address.
- `MEM_data_write` in 16: store data.
- `data_out` in 16: load data.
- `hlt` in 1: halt in MEM/WB.
- `exp_valid` in 1: expected record is present.
- `exp_kind` in 2: expected record kind.
- `exp_addr` in 16: expected record address.
- `exp_data` in 16: expected record data.
- `exp_ready` out 1: checker accepts the expected record this cycle.
- `err_valid` out 1: one-cycle pulse reporting one mismatch.
- `err_obs_kind` out 2, `err_obs_addr` out 16, `err_obs_data` out 16: observed record for the reported mismatch.
- `err_count` out 16: saturating error count.
- `inst_count` out 32: retired instruction count.
- `cycle_count` out 32: cycles spent in RUN.
- `overflow` out 1: sticky, set when a record is dropped.
- `timeout` out 1: sticky, set on cycle or drain timeout.
- `done` out 1: checking has finished.
- `pass` out 1: `done` with zero errors and no timeout.

Reset: every output is 0 and the state is RUN.

## Operation

Record kinds:
- REG=0: addr = {12'h000, `dstReg`}, data = `data_write_reg`.
- LOAD=1: addr = `MEM_ALU_result`, data = `data_out`.
- STORE=2: addr = `MEM_ALU_result`, data = `MEM_data_write`.
- END=3: addr and data are ignored.

Capture (RUN only):
- Each cycle, capture REG if `RegWrite`.
- Capture LOAD if `MEM_MemRead`, else STORE if `MEM_MemWrite`.
- If both REG and a memory record occur in one cycle, push REG first, then the memory record.
- A cycle with `hlt` high captures its records, then the state moves to DRAIN.

Counters (RUN only):
- `cycle_count` increments every RUN cycle.
- `inst_count` increments on cycles with `hlt`, `RegWrite` or `MEM_MemWrite` high.

State machine:
- RUN to DRAIN on `hlt`.
- RUN to DONE with `timeout` set when `cycle_count` reaches `MAX_CYCLES`.
- DRAIN to DONE on an END handshake, or with `timeout` set after `DRAIN_TIMEOUT` idle cycles.
- DONE is terminal until reset. Inputs are ignored and `exp_ready`=0.

Handshake:
- `exp_ready` = (state≠DONE) && (FIFO non-empty || state==DRAIN).
- A transfer occurs when `exp_valid` && `exp_ready`.

Compare, on each transfer:
- FIFO non-empty, `exp_kind`≠END: pop the head. Error if kind, addr or data differ; LOAD/STORE compare all 16 data bits.
- FIFO non-empty, `exp_kind`=END: one error, reporting the head record. Go to DONE; the remaining entries are not counted.
- FIFO empty in DRAIN, `exp_kind`≠END: one error (missing observed record), with `err_obs_kind`=END and addr/data 0. Stay in DRAIN.
- FIFO empty in DRAIN, `exp_kind`=END: go to DONE.

Errors:
- Each error increments `err_count`, which saturates at 16'hFFFF.

Overflow:
- The FIFO accepts up to 2 pushes and 1 pop per cycle.
- A push needing more than the free slots (counted after the same-cycle pop) drops the records that do not fit, starting with the later one.
- Each dropped record sets `overflow` and adds 1 error.

Reset mid-operation clears the FIFO, counters, flags and state immediately.

## Timing

- Capture at edge N makes the record visible at the FIFO head from cycle N+1. Minimum capture-to-compare latency is 1 cycle.
- Compare is combinational on the head and the expected record. `err_valid` and the `err_obs_*` fields are registered, asserting the cycle after the transfer.
- `err_count` updates on the same edge as `err_valid`.
- `done` and `pass` assert the cycle after the terminating transfer or timeout, then hold.
- `exp_ready` depends only on registered state; it has no combinational path from `exp_valid`.

## Structure

Shared package `trace_pkg`:
- kind constants `TR_REG`, `TR_LOAD`, `TR_STORE`, `TR_END`;
- `TR_W`=34;
- record pack/unpack layout {kind[33:32], addr[31:16], data[15:0]}.

One sub-module, `trace_fifo`: dual-push, single-pop, `FIFO_DEPTH`×34. It exposes count, full, empty and a drop count per cycle. Pointers wrap modulo `FIFO_DEPTH`.

## Test plan

- `RegWrite`, `dstReg`=3, data 16'h00A5, then `hlt`; expected REG(3, 00A5), END -> `done`=1, `pass`=1, `inst_count`=2, `err_count`=0.
- Same-cycle REG(r1, 1234) and STORE(addr 0040, data BEEF); expected stream in the order REG, STORE -> pass. Reversed expected order -> `err_count`=2, first `err_obs_kind`=REG.
- LOAD addr 0010, `data_out` 5A5A; expected LOAD data 5A5B -> `err_valid` pulses once, `err_obs_data`=5A5A, `pass`=0.
- `exp_valid` held 0 while 10 cycles of dual events are pushed with `FIFO_DEPTH`=8 -> `overflow`=1, `err_count`=12, FIFO holds the first 8 records.
- No `hlt` for `MAX_CYCLES`=50 -> `done` and `timeout` assert on cycle 51, `pass`=0. Separately, END arriving with 2 records still queued -> `err_count`=1, `done`=1.
- Assert `rst_n`=0 mid-DRAIN with 3 queued records -> all outputs 0 asynchronously; after release, a fresh one-record run passes.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - trace record layout, record kinds and checker states
package trace_pkg;

    localparam int TR_W = 34;

    localparam logic [1:0] TR_REG   = 2'd0;
    localparam logic [1:0] TR_LOAD  = 2'd1;
    localparam logic [1:0] TR_STORE = 2'd2;
    localparam logic [1:0] TR_END   = 2'd3;

    // Packed as {kind[33:32], addr[31:16], data[15:0]}
    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
    } trace_rec_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } chk_state_t;

    function automatic trace_rec_t packRec(input logic [1:0] kind, input logic [15:0] addr,
                                           input logic [15:0] data);
        trace_rec_t r;
        r.kind = kind;
        r.addr = addr;
        r.data = data;
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - dual-push single-pop record buffer with per-cycle drop count
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               pushCount,
    input  trace_rec_t               push0Rec,
    input  trace_rec_t               push1Rec,
    input  logic                     pop,
    output trace_rec_t               headRec,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [1:0]               dropCount
);
    localparam int AW = $clog2(DEPTH);

    trace_rec_t    mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   freeSlots;
    logic [1:0]    accepted;
    logic          popEn;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign popEn   = pop && !empty;
    assign headRec = mem[rdPtr];

    // Room freed by this cycle's pop is usable; the later record is the first to go
    always_comb begin
        freeSlots = (AW+1)'(DEPTH) - count + (AW+1)'(popEn);
        if ((AW+1)'(pushCount) <= freeSlots)
            accepted = pushCount;
        else
            accepted = freeSlots[1:0];
        dropCount = pushCount - accepted;
    end

    always_ff @(posedge clk) begin
        if (accepted != 2'd0)
            mem[wrPtr] <= push0Rec;
        if (accepted == 2'd2)
            mem[wrPtr + AW'(1)] <= push1Rec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            wrPtr <= wrPtr + AW'(accepted);
            rdPtr <= rdPtr + AW'(popEn);
            count <= count + (AW+1)'(accepted) - (AW+1)'(popEn);
        end
    end

endmodule

// File: rtl/commit_trace_checker.sv
// rtl/commit_trace_checker.sv - compares retired CPU events against an expected trace stream
module commit_trace_checker
    import trace_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int MAX_CYCLES    = 100000,
    parameter int DRAIN_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWrite,
    input  logic [3:0]  dstReg,
    input  logic [15:0] data_write_reg,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [15:0] MEM_ALU_result,
    input  logic [15:0] MEM_data_write,
    input  logic [15:0] data_out,
    input  logic        hlt,
    input  logic        exp_valid,
    input  logic [1:0]  exp_kind,
    input  logic [15:0] exp_addr,
    input  logic [15:0] exp_data,
    output logic        exp_ready,
    output logic        err_valid,
    output logic [1:0]  err_obs_kind,
    output logic [15:0] err_obs_addr,
    output logic [15:0] err_obs_data,
    output logic [15:0] err_count,
    output logic [31:0] inst_count,
    output logic [31:0] cycle_count,
    output logic        overflow,
    output logic        timeout,
    output logic        done,
    output logic        pass
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    chk_state_t    state, stateNext;
    trace_rec_t    push0Rec, push1Rec, headRec, errRec;
    logic [1:0]    pushCount, dropCount;
    logic [CW-1:0] fifoCount;
    logic          fifoFull, fifoEmpty, unusedFifo;
    logic          inRun, memHit, transfer, pop, cmpErr, endSeen, timeoutHit;
    logic [31:0]   drainIdle;
    logic [16:0]   errSum;

    assign inRun      = state == ST_RUN;
    assign memHit     = MEM_MemRead || MEM_MemWrite;
    assign unusedFifo = ^{fifoFull, fifoCount};

    // Records are compacted so a lone memory record always enters on push port 0
    always_comb begin
        push0Rec  = packRec(TR_REG, {12'h000, dstReg}, data_write_reg);
        push1Rec  = packRec(MEM_MemRead ? TR_LOAD : TR_STORE, MEM_ALU_result,
                            MEM_MemRead ? data_out : MEM_data_write);
        pushCount = 2'd0;
        if (inRun) begin
            if (RegWrite) begin
                pushCount = memHit ? 2'd2 : 2'd1;
            end else if (memHit) begin
                push0Rec  = push1Rec;
                pushCount = 2'd1;
            end
        end
    end

    trace_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .pushCount (pushCount),
        .push0Rec  (push0Rec),
        .push1Rec  (push1Rec),
        .pop       (pop),
        .headRec   (headRec),
        .count     (fifoCount),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .dropCount (dropCount)
    );

    assign exp_ready = (state != ST_DONE) && (!fifoEmpty || state == ST_DRAIN);
    assign transfer  = exp_valid && exp_ready;

    always_comb begin
        pop     = 1'b0;
        cmpErr  = 1'b0;
        endSeen = 1'b0;
        errRec  = headRec;
        if (transfer) begin
            if (!fifoEmpty) begin
                if (exp_kind != TR_END) begin
                    pop    = 1'b1;
                    cmpErr = headRec != packRec(exp_kind, exp_addr, exp_data);
                end else begin
                    cmpErr  = 1'b1;
                    endSeen = 1'b1;
                end
            end else if (exp_kind != TR_END) begin
                cmpErr = 1'b1;
                errRec = packRec(TR_END, 16'h0000, 16'h0000);
            end else begin
                endSeen = 1'b1;
            end
        end
    end

    always_comb begin
        stateNext  = state;
        timeoutHit = 1'b0;
        case (state)
            ST_RUN: begin
                if (endSeen) begin
                    stateNext = ST_DONE;
                end else if (hlt) begin
                    stateNext = ST_DRAIN;
                end else if (cycle_count == 32'(MAX_CYCLES - 1)) begin
                    stateNext  = ST_DONE;
                    timeoutHit = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (endSeen) begin
                    stateNext = ST_DONE;
                end else if (!transfer && drainIdle == 32'(DRAIN_TIMEOUT - 1)) begin
                    stateNext  = ST_DONE;
                    timeoutHit = 1'b1;
                end
            end
            default: stateNext = state;
        endcase
    end

    assign errSum = {1'b0, err_count} + 17'(cmpErr) + 17'(dropCount);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            err_valid    <= 1'b0;
            err_obs_kind <= '0;
            err_obs_addr <= '0;
            err_obs_data <= '0;
            err_count    <= '0;
            inst_count   <= '0;
            cycle_count  <= '0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
            drainIdle    <= '0;
        end else begin
            state     <= stateNext;
            err_valid <= cmpErr;
            if (cmpErr) begin
                err_obs_kind <= errRec.kind;
                err_obs_addr <= errRec.addr;
                err_obs_data <= errRec.data;
            end
            err_count <= errSum[16] ? 16'hFFFF : errSum[15:0];
            if (dropCount != 2'd0)
                overflow <= 1'b1;
            if (timeoutHit)
                timeout <= 1'b1;
            if (inRun) begin
                cycle_count <= cycle_count + 32'd1;
                if (hlt || RegWrite || MEM_MemWrite)
                    inst_count <= inst_count + 32'd1;
            end
            if (state == ST_DRAIN && !transfer)
                drainIdle <= drainIdle + 32'd1;
            else
                drainIdle <= '0;
        end
    end

    assign done = state == ST_DONE;
    assign pass = done && err_count == 16'd0 && !timeout;

endmodule

// File: tb/tb_commit_trace_checker.sv
// tb/tb_commit_trace_checker.sv - scoreboard bench for commit_trace_checker
module tb_commit_trace_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite, MEM_MemRead, MEM_MemWrite, hlt, exp_valid;
    logic [3:0]  dstReg;
    logic [15:0] data_write_reg, MEM_ALU_result, MEM_data_write, data_out;
    logic [1:0]  exp_kind;
    logic [15:0] exp_addr, exp_data;
    logic        exp_ready, err_valid, overflow, timeout, done, pass;
    logic [1:0]  err_obs_kind;
    logic [15:0] err_obs_addr, err_obs_data, err_count;
    logic [31:0] inst_count, cycle_count;

    int nChecks = 0;
    int nFails  = 0;
    logic [33:0] expQ[$];
    logic [33:0] obsQ[$];
    int obsRd = 0;

    always #5 clk = ~clk;

    commit_trace_checker #(.FIFO_DEPTH(8), .MAX_CYCLES(50), .DRAIN_TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .dstReg(dstReg),
        .data_write_reg(data_write_reg), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_ALU_result(MEM_ALU_result), .MEM_data_write(MEM_data_write), .data_out(data_out),
        .hlt(hlt), .exp_valid(exp_valid), .exp_kind(exp_kind), .exp_addr(exp_addr),
        .exp_data(exp_data), .exp_ready(exp_ready), .err_valid(err_valid),
        .err_obs_kind(err_obs_kind), .err_obs_addr(err_obs_addr), .err_obs_data(err_obs_data),
        .err_count(err_count), .inst_count(inst_count), .cycle_count(cycle_count),
        .overflow(overflow), .timeout(timeout), .done(done), .pass(pass)
    );

    always @(negedge clk)
        if (rst_n === 1'b1 && err_valid === 1'b1)
            obsQ.push_back({err_obs_kind, err_obs_addr, err_obs_data});

    task automatic clearInputs();
        RegWrite = 0; dstReg = 0; data_write_reg = 0; MEM_MemRead = 0; MEM_MemWrite = 0;
        MEM_ALU_result = 0; MEM_data_write = 0; data_out = 0; hlt = 0;
    endtask

    task automatic doReset();
        clearInputs();
        exp_valid = 0; exp_kind = 0; exp_addr = 0; exp_data = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        expQ.delete();
        obsRd = obsQ.size();
    endtask

    task automatic drive(input logic rw, input logic [3:0] dst, input logic [15:0] wd,
                         input logic mr, input logic mw, input logic [15:0] addr,
                         input logic [15:0] sd, input logic [15:0] dout, input logic h);
        RegWrite = rw; dstReg = dst; data_write_reg = wd; MEM_MemRead = mr; MEM_MemWrite = mw;
        MEM_ALU_result = addr; MEM_data_write = sd; data_out = dout; hlt = h;
        @(negedge clk);
        clearInputs();
    endtask

    task automatic sendExp(input logic [1:0] k, input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        exp_valid = 1; exp_kind = k; exp_addr = a; exp_data = d;
        while (exp_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            nChecks++; nFails++;
            $display("FAIL handshake_wait: exp_ready stayed %b, required 1 within 100 cycles", exp_ready);
        end
        @(negedge clk);
        exp_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clearInputs();
        exp_valid = 0; exp_kind = 0; exp_addr = 0; exp_data = 0;
        #3;
        nChecks++;
        if ({exp_ready, err_valid, overflow, timeout, done, pass} !== 6'b0) begin
            nFails++;
            $display("FAIL reset_flags: got %b required 000000",
                     {exp_ready, err_valid, overflow, timeout, done, pass});
        end
        nChecks++;
        if ({err_count, inst_count, cycle_count} !== 80'h0) begin
            nFails++;
            $display("FAIL reset_counters: got %h required 0", {err_count, inst_count, cycle_count});
        end
        nChecks++;
        if ({err_obs_kind, err_obs_addr, err_obs_data} !== 34'h0) begin
            nFails++;
            $display("FAIL reset_obs: got %h required 0", {err_obs_kind, err_obs_addr, err_obs_data});
        end
    endtask

    task automatic test_single_reg();
        doReset();
        RegWrite = 1; dstReg = 4'd3; data_write_reg = 16'h00A5;
        @(negedge clk);
        clearInputs();
        nChecks++;
        if (exp_ready !== 1'b1) begin nFails++; $display("FAIL single_latency: exp_ready %b required 1", exp_ready); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        sendExp(2'd0, 16'h0003, 16'h00A5);
        sendExp(2'd3, 16'h0, 16'h0);
        nChecks++;
        if ({done, pass, timeout} !== 3'b110) begin nFails++; $display("FAIL single_verdict: done/pass/timeout %b required 110", {done, pass, timeout}); end
        nChecks++;
        if (inst_count !== 32'd2) begin nFails++; $display("FAIL single_inst: got %0d required 2", inst_count); end
        nChecks++;
        if (cycle_count !== 32'd2) begin nFails++; $display("FAIL single_cycles: got %0d required 2", cycle_count); end
        nChecks++;
        if (err_count !== 16'd0) begin nFails++; $display("FAIL single_errs: got %0d required 0", err_count); end
        nChecks++;
        if (exp_ready !== 1'b0) begin nFails++; $display("FAIL single_done_ready: got %b required 0", exp_ready); end
        #1;
        nChecks++;
        if (obsQ.size() - obsRd !== 0) begin nFails++; $display("FAIL single_pulses: got %0d required 0", obsQ.size() - obsRd); end
    endtask

    task automatic test_dual_order();
        doReset();
        drive(1, 4'd1, 16'h1234, 0, 1, 16'h0040, 16'hBEEF, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        sendExp(2'd0, 16'h0001, 16'h1234);
        sendExp(2'd2, 16'h0040, 16'hBEEF);
        sendExp(2'd3, 16'h0, 16'h0);
        nChecks++;
        if ({done, pass, err_count} !== {2'b11, 16'd0}) begin nFails++; $display("FAIL dual_pass: done/pass/errs %b/%b/%0d required 1/1/0", done, pass, err_count); end
        nChecks++;
        if (inst_count !== 32'd2) begin nFails++; $display("FAIL dual_inst: got %0d required 2", inst_count); end

        doReset();
        drive(1, 4'd1, 16'h1234, 0, 1, 16'h0040, 16'hBEEF, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        expQ.push_back({2'd0, 16'h0001, 16'h1234});
        sendExp(2'd2, 16'h0040, 16'hBEEF);
        expQ.push_back({2'd2, 16'h0040, 16'hBEEF});
        sendExp(2'd0, 16'h0001, 16'h1234);
        sendExp(2'd3, 16'h0, 16'h0);
        nChecks++;
        if ({done, pass, err_count} !== {2'b10, 16'd2}) begin nFails++; $display("FAIL dual_reversed: done/pass/errs %b/%b/%0d required 1/0/2", done, pass, err_count); end
        #1;
        nChecks++;
        if (obsQ.size() - obsRd !== expQ.size()) begin nFails++; $display("FAIL dual_pulses: got %0d required %0d", obsQ.size() - obsRd, expQ.size()); end
        while (expQ.size() > 0 && obsRd < obsQ.size()) begin
            logic [33:0] e;
            e = expQ.pop_front();
            nChecks++;
            if (obsQ[obsRd] !== e) begin nFails++; $display("FAIL dual_report: got %h required %h", obsQ[obsRd], e); end
            obsRd++;
        end
    endtask

    task automatic test_load_mismatch();
        doReset();
        drive(0, 0, 0, 1, 0, 16'h0010, 16'h0, 16'h5A5A, 1);
        expQ.push_back({2'd1, 16'h0010, 16'h5A5A});
        sendExp(2'd1, 16'h0010, 16'h5A5B);
        nChecks++;
        if ({err_valid, err_obs_data} !== {1'b1, 16'h5A5A}) begin nFails++; $display("FAIL load_pulse: valid/data %b/%h required 1/5a5a", err_valid, err_obs_data); end
        sendExp(2'd3, 16'h0, 16'h0);
        nChecks++;
        if (err_valid !== 1'b0) begin nFails++; $display("FAIL load_pulse_width: got %b required 0", err_valid); end
        nChecks++;
        if ({done, pass, err_count} !== {2'b10, 16'd1}) begin nFails++; $display("FAIL load_verdict: done/pass/errs %b/%b/%0d required 1/0/1", done, pass, err_count); end
        #1;
        nChecks++;
        if (obsQ.size() - obsRd !== expQ.size()) begin nFails++; $display("FAIL load_pulses: got %0d required %0d", obsQ.size() - obsRd, expQ.size()); end
        while (expQ.size() > 0 && obsRd < obsQ.size()) begin
            logic [33:0] e;
            e = expQ.pop_front();
            nChecks++;
            if (obsQ[obsRd] !== e) begin nFails++; $display("FAIL load_report: got %h required %h", obsQ[obsRd], e); end
            obsRd++;
        end
    endtask

    task automatic test_overflow();
        doReset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 4'(i), 16'(16'h1000 + i), 0, 1, 16'(16'h0200 + i), 16'(16'h2000 + i), 0, 0);
            if (i == 3) begin
                nChecks++;
                if ({overflow, err_count} !== {1'b0, 16'd0}) begin nFails++; $display("FAIL ovf_full_edge: ovf/errs %b/%0d required 0/0", overflow, err_count); end
            end
            if (i == 4) begin
                nChecks++;
                if ({overflow, err_count} !== {1'b1, 16'd2}) begin nFails++; $display("FAIL ovf_first_drop: ovf/errs %b/%0d required 1/2", overflow, err_count); end
            end
        end
        nChecks++;
        if ({overflow, err_count} !== {1'b1, 16'd12}) begin nFails++; $display("FAIL ovf_total: ovf/errs %b/%0d required 1/12", overflow, err_count); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            sendExp(2'd0, 16'(i), 16'(16'h1000 + i));
            sendExp(2'd2, 16'(16'h0200 + i), 16'(16'h2000 + i));
        end
        sendExp(2'd3, 16'h0, 16'h0);
        nChecks++;
        if ({done, pass, err_count} !== {2'b10, 16'd12}) begin nFails++; $display("FAIL ovf_contents: done/pass/errs %b/%b/%0d required 1/0/12", done, pass, err_count); end
        nChecks++;
        if (inst_count !== 32'd11) begin nFails++; $display("FAIL ovf_inst: got %0d required 11", inst_count); end
        #1;
        nChecks++;
        if (obsQ.size() - obsRd !== 0) begin nFails++; $display("FAIL ovf_pulses: got %0d required 0", obsQ.size() - obsRd); end
        obsRd = obsQ.size();
    endtask

    task automatic test_timeout();
        doReset();
        repeat (49) @(negedge clk);
        nChecks++;
        if ({done, timeout, cycle_count} !== {2'b00, 32'd49}) begin nFails++; $display("FAIL run_timeout_early: done/timeout/cycles %b/%b/%0d required 0/0/49", done, timeout, cycle_count); end
        @(negedge clk);
        nChecks++;
        if ({done, timeout, pass, cycle_count} !== {3'b110, 32'd50}) begin nFails++; $display("FAIL run_timeout: done/timeout/pass/cycles %b/%b/%b/%0d required 1/1/0/50", done, timeout, pass, cycle_count); end
        repeat (3) @(negedge clk);
        nChecks++;
        if ({done, cycle_count} !== {1'b1, 32'd50}) begin nFails++; $display("FAIL run_timeout_hold: done/cycles %b/%0d required 1/50", done, cycle_count); end

        doReset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (19) @(negedge clk);
        nChecks++;
        if ({done, timeout} !== 2'b00) begin nFails++; $display("FAIL drain_timeout_early: done/timeout %b required 00", {done, timeout}); end
        @(negedge clk);
        nChecks++;
        if ({done, timeout, pass} !== 3'b110) begin nFails++; $display("FAIL drain_timeout: done/timeout/pass %b required 110", {done, timeout, pass}); end
    endtask

    task automatic test_end_early();
        doReset();
        drive(1, 4'd2, 16'h2222, 1, 0, 16'h0080, 16'h0, 16'h3333, 1);
        expQ.push_back({2'd0, 16'h0002, 16'h2222});
        sendExp(2'd3, 16'h0, 16'h0);
        nChecks++;
        if ({done, pass, timeout, err_count} !== {3'b100, 16'd1}) begin nFails++; $display("FAIL end_early: done/pass/timeout/errs %b/%b/%b/%0d required 1/0/0/1", done, pass, timeout, err_count); end
        #1;
        nChecks++;
        if (obsQ.size() - obsRd !== expQ.size()) begin nFails++; $display("FAIL end_early_pulses: got %0d required %0d", obsQ.size() - obsRd, expQ.size()); end
        while (expQ.size() > 0 && obsRd < obsQ.size()) begin
            logic [33:0] e;
            e = expQ.pop_front();
            nChecks++;
            if (obsQ[obsRd] !== e) begin nFails++; $display("FAIL end_early_report: got %h required %h", obsQ[obsRd], e); end
            obsRd++;
        end
    endtask

    task automatic test_reset_mid_drain();
        doReset();
        drive(1, 4'd4, 16'h4444, 0, 1, 16'h0044, 16'h4455, 0, 0);
        drive(1, 4'd5, 16'h5555, 1, 0, 16'h0055, 16'h0, 16'h5566, 1);
        expQ.push_back({2'd0, 16'h0004, 16'h4444});
        sendExp(2'd0, 16'h0004, 16'h4440);
        nChecks++;
        if ({err_count, exp_ready} !== {16'd1, 1'b1}) begin nFails++; $display("FAIL drain_before_reset: errs/ready %0d/%b required 1/1", err_count, exp_ready); end
        #1;
        while (expQ.size() > 0 && obsRd < obsQ.size()) begin
            logic [33:0] e;
            e = expQ.pop_front();
            nChecks++;
            if (obsQ[obsRd] !== e) begin nFails++; $display("FAIL drain_report: got %h required %h", obsQ[obsRd], e); end
            obsRd++;
        end
        nChecks++;
        if (expQ.size() !== 0) begin nFails++; $display("FAIL drain_pulses: %0d reports missing, required 0", expQ.size()); end
        #1;
        rst_n = 0;
        #1;
        nChecks++;
        if ({exp_ready, err_valid, overflow, timeout, done, pass, err_count, inst_count, cycle_count} !== 86'h0) begin
            nFails++;
            $display("FAIL async_reset: ready/errs/inst/cycles %b/%0d/%0d/%0d required all 0", exp_ready, err_count, inst_count, cycle_count);
        end
        @(negedge clk);
        rst_n = 1;
        obsRd = obsQ.size();
        drive(1, 4'd7, 16'h7777, 0, 0, 0, 0, 0, 1);
        sendExp(2'd0, 16'h0007, 16'h7777);
        sendExp(2'd3, 16'h0, 16'h0);
        nChecks++;
        if ({done, pass, err_count, inst_count} !== {2'b11, 16'd0, 32'd1}) begin nFails++; $display("FAIL fresh_run: done/pass/errs/inst %b/%b/%0d/%0d required 1/1/0/1", done, pass, err_count, inst_count); end
    endtask

    initial begin
        test_reset();
        test_single_reg();
        test_dual_order();
        test_load_mismatch();
        test_overflow();
        test_timeout();
        test_end_early();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
